unified_memory_hs: RTL and testbench

UNIFIED_MEMORY_HS -- requirements
Module: unified_memory_hs

---
 rtl/unified_memory_hs.sv | 106 ++++++++++
 tb/tb_unified_memory_hs.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_memory_hs.sv
// unified_memory_hs: dual-port byte-enable RAM with req/ready handshake and fixed-latency responses.
module unified_memory_hs #(
    parameter int    NB_COL       = 4,
    parameter int    COL_WIDTH    = 8,
    parameter int    RAM_DEPTH    = 1024,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "",
    localparam int   W            = NB_COL * COL_WIDTH,
    localparam int   AW           = $clog2(RAM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_a_i,
    output logic              ready_a_o,
    input  logic [AW-1:0]     addr_a_i,
    input  logic [NB_COL-1:0] we_a_i,
    input  logic [W-1:0]      din_a_i,
    output logic              rvalid_a_o,
    output logic [W-1:0]      dout_a_o,
    input  logic              req_b_i,
    output logic              ready_b_o,
    input  logic [AW-1:0]     addr_b_i,
    input  logic [NB_COL-1:0] we_b_i,
    input  logic [W-1:0]      din_b_i,
    output logic              rvalid_b_o,
    output logic [W-1:0]      dout_b_o
);
    localparam logic [AW:0] DEPTH = (AW + 1)'(RAM_DEPTH);

    logic [W-1:0]      mem_q [RAM_DEPTH] = '{default: '0};
    logic [AW-1:0]     addr [2];
    logic [NB_COL-1:0] we [2];
    logic [W-1:0]      din [2];
    logic [W-1:0]      rd_d [2];
    logic [W-1:0]      d1_q [2];
    logic [W-1:0]      dout [2];
    logic [1:0]        req, acc, in_rng, v1_q, vout;

    assign addr[0] = addr_a_i;
    assign addr[1] = addr_b_i;
    assign we[0]   = we_a_i;
    assign we[1]   = we_b_i;
    assign din[0]  = din_a_i;
    assign din[1]  = din_b_i;
    assign req     = {req_b_i, req_a_i};

    assign ready_a_o = !rst_i;
    assign ready_b_o = !rst_i && !(req_a_i && req_b_i && addr_a_i == addr_b_i && |(we_a_i & we_b_i));
    assign acc       = req & {ready_b_o, ready_a_o};

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            in_rng[p] = {1'b0, addr[p]} < DEPTH;
            rd_d[p] = in_rng[p] ? mem_q[addr[p]] : '0;
`ifdef UNIFIED_MEMORY_BYPASS_EN
            for (int k = 0; k < NB_COL; k++)
                if (acc[1-p] && in_rng[p] && addr[1-p] == addr[p] && we[1-p][k])
                    rd_d[p][k*COL_WIDTH +: COL_WIDTH] = din[1-p][k*COL_WIDTH +: COL_WIDTH];
`endif
        end
    end

    always_ff @(posedge clk_i)
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < NB_COL; k++)
                if (acc[p] && in_rng[p] && we[p][k])
                    mem_q[addr[p]][k*COL_WIDTH +: COL_WIDTH] <= din[p][k*COL_WIDTH +: COL_WIDTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q <= '0;
            d1_q <= '{default: '0};
        end else begin
            v1_q <= acc;
            for (int p = 0; p < 2; p++)
                if (acc[p]) d1_q[p] <= rd_d[p];
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign vout = v1_q;
        assign dout = d1_q;
    end else if (READ_LATENCY == 2) begin : g_lat2
        logic [1:0]   v2_q;
        logic [W-1:0] d2_q [2];
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v2_q <= '0;
                d2_q <= '{default: '0};
            end else begin
                v2_q <= v1_q;
                for (int p = 0; p < 2; p++)
                    if (v1_q[p]) d2_q[p] <= d1_q[p];
            end
        end
        assign vout = v2_q;
        assign dout = d2_q;
    end else begin : g_bad
        $error("unified_memory_hs: READ_LATENCY must be 1 or 2");
    end

    assign rvalid_a_o = vout[0];
    assign rvalid_b_o = vout[1];
    assign dout_a_o   = dout[0];
    assign dout_b_o   = dout[1];
endmodule

// File: tb/tb_unified_memory_hs.sv
// tb_unified_memory_hs: scoreboard bench driving a latency-1 and a latency-2 instance with identical stimulus.
module tb_unified_memory_hs;
    localparam int DEPTH = 1000;

    typedef struct {
        logic [31:0] d;
        int          c;
        string       n;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        req_a = 0, req_b = 0;
    logic [9:0]  addr_a = 0, addr_b = 0;
    logic [3:0]  we_a = 0, we_b = 0;
    logic [31:0] din_a = 0, din_b = 0;
    logic        rdy_s [4];
    logic        rv_s [4];
    logic [31:0] do_s [4];

    exp_t        sbq [4][$];
    exp_t        mon_e;
    logic [31:0] m [1024];
    logic [31:0] last [4];
    int          cyc = 0, errors = 0, checks = 0;
    bit          mon_en = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unified_memory_hs #(.RAM_DEPTH(DEPTH), .READ_LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst),
        .req_a_i(req_a), .ready_a_o(rdy_s[0]), .addr_a_i(addr_a), .we_a_i(we_a), .din_a_i(din_a),
        .rvalid_a_o(rv_s[0]), .dout_a_o(do_s[0]),
        .req_b_i(req_b), .ready_b_o(rdy_s[1]), .addr_b_i(addr_b), .we_b_i(we_b), .din_b_i(din_b),
        .rvalid_b_o(rv_s[1]), .dout_b_o(do_s[1])
    );

    unified_memory_hs #(.RAM_DEPTH(DEPTH), .READ_LATENCY(2)) u_lat2 (
        .clk_i(clk), .rst_i(rst),
        .req_a_i(req_a), .ready_a_o(rdy_s[2]), .addr_a_i(addr_a), .we_a_i(we_a), .din_a_i(din_a),
        .rvalid_a_o(rv_s[2]), .dout_a_o(do_s[2]),
        .req_b_i(req_b), .ready_b_o(rdy_s[3]), .addr_b_i(addr_b), .we_b_i(we_b), .din_b_i(din_b),
        .rvalid_b_o(rv_s[3]), .dout_b_o(do_s[3])
    );

    // Streams: 0/1 = latency-1 A/B, 2/3 = latency-2 A/B.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int s = 0; s < 4; s++) begin
                checks++;
                if (rv_s[s] === 1'b1) begin
                    if (sbq[s].size() == 0) begin
                        errors++;
                        $display("FAIL spurious_rvalid stream %0d: got rvalid with dout=%h, expected no response", s, do_s[s]);
                    end else begin
                        mon_e = sbq[s].pop_front();
                        if (do_s[s] !== mon_e.d || cyc - mon_e.c != (s < 2 ? 1 : 2)) begin
                            errors++;
                            $display("FAIL %s stream %0d: got dout=%h after %0d cycles, expected %h after %0d",
                                     mon_e.n, s, do_s[s], cyc - mon_e.c, mon_e.d, (s < 2 ? 1 : 2));
                        end
                    end
                    last[s] = do_s[s];
                end else if (rv_s[s] !== 1'b0 || do_s[s] !== last[s]) begin
                    errors++;
                    $display("FAIL dout_hold stream %0d: got rvalid=%b dout=%h, expected rvalid=0 dout=%h", s, rv_s[s], do_s[s], last[s]);
                end
            end
        end
    end

    task automatic cycle(input logic ra, input logic [9:0] aa, input logic [3:0] wa, input logic [31:0] da,
                         input logic rb, input logic [9:0] ab, input logic [3:0] wb, input logic [31:0] db,
                         input string nm);
        logic        ea, eb, rdyb;
        logic [31:0] rda, rdb;
        exp_t        ex;
        req_a = ra; addr_a = aa; we_a = wa; din_a = da;
        req_b = rb; addr_b = ab; we_b = wb; din_b = db;
        @(negedge clk);
        rdyb = !rst && !(ra && rb && aa == ab && (wa & wb) != 0);
        ea = ra && !rst;
        eb = rb && rdyb;
        checks++;
        if ({rdy_s[0], rdy_s[2]} !== {2{!rst}} || {rdy_s[1], rdy_s[3]} !== {2{rdyb}}) begin
            errors++;
            $display("FAIL ready_%s: got a=%b%b b=%b%b, expected a=%b b=%b", nm, rdy_s[0], rdy_s[2], rdy_s[1], rdy_s[3], !rst, rdyb);
        end
        rda = aa < DEPTH ? m[aa] : 32'h0;
        rdb = ab < DEPTH ? m[ab] : 32'h0;
`ifdef UNIFIED_MEMORY_BYPASS_EN
        for (int k = 0; k < 4; k++) begin
            if (eb && wb[k] && ab == aa && aa < DEPTH) rda[8*k +: 8] = db[8*k +: 8];
            if (ea && wa[k] && aa == ab && ab < DEPTH) rdb[8*k +: 8] = da[8*k +: 8];
        end
`endif
        ex.c = cyc;
        ex.n = nm;
        if (ea) begin
            ex.d = rda;
            sbq[0].push_back(ex);
            sbq[2].push_back(ex);
        end
        if (eb) begin
            ex.d = rdb;
            sbq[1].push_back(ex);
            sbq[3].push_back(ex);
        end
        for (int k = 0; k < 4; k++) begin
            if (ea && aa < DEPTH && wa[k]) m[aa][8*k +: 8] = da[8*k +: 8];
            if (eb && ab < DEPTH && wb[k]) m[ab][8*k +: 8] = db[8*k +: 8];
        end
        @(posedge clk);
        if (rst) begin
            for (int s = 0; s < 4; s++) begin
                sbq[s].delete();
                last[s] = 32'h0;
            end
        end
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, "idle");
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (rv_s[s] !== 1'b0 || do_s[s] !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs stream %0d: got rvalid=%b dout=%h, expected 0/0", s, rv_s[s], do_s[s]);
            end
        end
        idle();
        rst = 0;
        mon_en = 1;
    endtask

    task automatic test_write_read();
        cycle(1, 5, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, "wr5");
        cycle(1, 5, 4'h0, 32'h0, 0, 0, 0, 0, "rd5");
        checks++;
        if (rv_s[0] !== 1'b1 || do_s[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_read: got rvalid=%b dout=%h, expected 1/deadbeef", rv_s[0], do_s[0]);
        end
        idle();
        idle();
    endtask

    task automatic test_byte_write();
        cycle(1, 5, 4'b0010, 32'h0000AB00, 0, 0, 0, 0, "bw5");
        cycle(1, 5, 4'h0, 32'h0, 1, 5, 4'h0, 32'h0, "rd5_bw");
        checks++;
        if (do_s[0] !== 32'hDEADABEF || do_s[1] !== 32'hDEADABEF) begin
            errors++;
            $display("FAIL byte_write: got a=%h b=%h, expected deadabef", do_s[0], do_s[1]);
        end
        idle();
        idle();
    endtask

    task automatic test_collision();
        cycle(1, 7, 4'hF, 32'h1, 1, 7, 4'hF, 32'h2, "col7");
        cycle(0, 0, 4'h0, 32'h0, 1, 7, 4'hF, 32'h2, "col7_b");
        cycle(1, 7, 4'h0, 32'h0, 0, 0, 4'h0, 32'h0, "rd7");
        checks++;
        if (do_s[0] !== 32'h2) begin
            errors++;
            $display("FAIL collision: got %h, expected 00000002", do_s[0]);
        end
        cycle(1, 8, 4'b0011, 32'hAAAA5555, 1, 8, 4'b1100, 32'h3333CCCC, "disjoint8");
        cycle(1, 8, 4'h0, 32'h0, 0, 0, 4'h0, 32'h0, "rd8");
        checks++;
        if (do_s[0] !== 32'h33335555) begin
            errors++;
            $display("FAIL disjoint_lanes: got %h, expected 33335555", do_s[0]);
        end
        idle();
        idle();
    endtask

    task automatic test_cross_port();
        logic [31:0] exp_b;
`ifdef UNIFIED_MEMORY_BYPASS_EN
        exp_b = 32'h11111111;
`else
        exp_b = 32'h0;
`endif
        cycle(1, 9, 4'hF, 32'h11111111, 1, 9, 4'h0, 32'h0, "xport9");
        checks++;
        if (do_s[1] !== exp_b) begin
            errors++;
            $display("FAIL cross_port: got %h, expected %h", do_s[1], exp_b);
        end
        cycle(1, 9, 4'h0, 32'h0, 1, 9, 4'b0101, 32'h00220022, "xport9_rev");
        idle();
        idle();
    endtask

    task automatic test_reset_inflight();
        cycle(1, 5, 4'h0, 32'h0, 1, 7, 4'h0, 32'h0, "inflight");
        rst = 1;
        cycle(1, 5, 4'hF, 32'hFFFFFFFF, 1, 7, 4'h0, 32'h0, "wr_in_rst");
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (rv_s[s] !== 1'b0 || do_s[s] !== 32'h0) begin
                errors++;
                $display("FAIL reset_inflight stream %0d: got rvalid=%b dout=%h, expected 0/0", s, rv_s[s], do_s[s]);
            end
        end
        rst = 0;
        idle();
        idle();
        cycle(1, 5, 4'h0, 32'h0, 1, 7, 4'h0, 32'h0, "reread");
        checks++;
        if (do_s[0] !== 32'hDEADABEF || do_s[1] !== 32'h2) begin
            errors++;
            $display("FAIL mem_after_reset: got a=%h b=%h, expected deadabef/00000002", do_s[0], do_s[1]);
        end
        idle();
        idle();
    endtask

    task automatic test_out_of_range();
        cycle(1, 10'd1000, 4'hF, 32'hFFFFFFFF, 1, 10'd1023, 4'hF, 32'h12345678, "oor_wr");
        cycle(1, 10'd1000, 4'h0, 32'h0, 1, 10'd0, 4'h0, 32'h0, "oor_rd");
        checks++;
        if (rv_s[0] !== 1'b1 || do_s[0] !== 32'h0 || do_s[1] !== 32'h0) begin
            errors++;
            $display("FAIL out_of_range: got rvalid=%b oor=%h addr0=%h, expected 1/0/0", rv_s[0], do_s[0], do_s[1]);
        end
        idle();
        idle();
    endtask

    task automatic test_back_to_back();
        logic [9:0] a1, a2;
        logic [3:0] w1, w2;
        for (int i = 0; i < 16; i++)
            cycle(1, 10'(i), 4'h0, 32'h0, 1, 10'(15 - i), 4'h0, 32'h0, "burst_rd");
        for (int i = 0; i < 80; i++) begin
            a1 = ($urandom_range(0, 7) == 0) ? 10'(1000 + $urandom_range(0, 23)) : 10'($urandom_range(0, 15));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 10'($urandom_range(0, 15));
            w1 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            w2 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            cycle($urandom_range(0, 4) != 0, a1, w1, $urandom, $urandom_range(0, 4) != 0, a2, w2, $urandom, "random");
        end
        for (int i = 0; i < 16; i++)
            cycle(1, 10'(i), 4'h0, 32'h0, 0, 0, 4'h0, 32'h0, "final_rd");
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) idle();
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (sbq[s].size() != 0) begin
                errors++;
                $display("FAIL missing_rvalid stream %0d: got %0d responses outstanding, expected 0", s, sbq[s].size());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) m[i] = 32'h0;
        for (int s = 0; s < 4; s++) last[s] = 32'h0;
        test_reset();
        test_write_read();
        test_byte_write();
        test_collision();
        test_cross_port();
        test_reset_inflight();
        test_out_of_range();
        test_back_to_back();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
